pieo_result_monitor: RTL and testbench
======================================

PIEO_RESULT_MONITOR -- requirements
Module: pieo_result_monitor

Interface
REQ-001 SHALL have these parameters (name, default, meaning): ELEM_W, 32, dequeued-element width | SUB_W, 5, sublist-index width | ID_W, 10, flow-id width excl. flag bit | DEPTH, 8, record FIFO depth (power of 2, >=2).
REQ-002 SHALL have one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-003 SHALL have these ports (name, direction, width, meaning): clk  in  1  clock | rst  in  1  async active-high reset.
REQ-004 SHALL have these PIEO-side inputs: pieo_reset_done_in 1 | pieo_ready_in 1 | enq_valid_in 1 | enq_sublist_in SUB_W | deq_valid_in 1 | deq_element_in ELEM_W | moved_id_in ID_W+1 | moved_sublist_in SUB_W.
REQ-005 SHALL have these control inputs: flush_in 1 (single-cycle pulse, drain FIFO) | clear_in 1 (single-cycle pulse, clear statistics and FIFO).
REQ-006 SHALL have these record-stream ports: rec_valid out 1 | rec_ready in 1 | rec_data out REC_W, where REC_W = 3+SUB_W+ELEM_W+ID_W+1+SUB_W.
REQ-007 SHALL have these status outputs: enq_count, deq_count, drop_count, stall_count, signature (out, 32 each) | overflow out 1 (sticky) | state_out out 2.

Function
REQ-008 SHALL implement a 3-state FSM with encodings IDLE=0, RUN=1, FLUSH=2: IDLE->RUN when pieo_reset_done_in=1; RUN->FLUSH on flush_in; FLUSH->RUN when the FIFO is empty; RUN or FLUSH->IDLE when pieo_reset_done_in=0, with priority over all other transitions.
REQ-009 SHALL detect a move event when moved_id_in[ID_W]=0; an MSB of 1 means no move.
REQ-010 SHALL define an event cycle as a cycle in RUN or FLUSH in which any of enq_valid_in, deq_valid_in or the move flag is 1; all events in IDLE are ignored.
REQ-011 SHALL pack the record as {move, deq, enq, enq_sublist_in, deq_element_in, moved_id_in, moved_sublist_in}, MSB first, with exactly one record per event cycle, so simultaneous events share a record.
REQ-012 SHALL push the record into the FIFO in RUN only; if the FIFO is full and not popped in the same cycle, it SHALL drop the record, increment drop_count and set overflow.
REQ-013 SHALL accept the push when the FIFO is full and popped in the same cycle (rec_valid&rec_ready).
REQ-014 SHALL hold rec_valid high whenever the FIFO is non-empty, with rec_data equal to the oldest record; rec_data SHALL stay stable while rec_valid&!rec_ready.
REQ-015 SHALL give a push-to-rec_valid latency of 1 cycle into an empty FIFO, with records delivered in order.
REQ-016 SHALL NOT push in FLUSH or IDLE; draining via rec_ready SHALL continue in all states.
REQ-017 SHALL update the counters in RUN and FLUSH: enq_count +1 on enq_valid_in; deq_count +1 on deq_valid_in; stall_count +1 on pieo_ready_in=0.
REQ-018 SHALL saturate all counters at 32'hFFFF_FFFF.
REQ-019 SHALL update signature on each event cycle as sig <= {sig[30:0],sig[31]} ^ F, where F is the XOR of the 32-bit chunks of the record zero-extended to a multiple of 32 bits.
REQ-020 SHALL update the signature on every event cycle, including dropped and FLUSH cycles.
REQ-021 SHALL, on clear_in, zero all counters, signature and overflow and empty the FIFO on the next edge, without changing the FSM state; a same-cycle event SHALL be discarded.
REQ-022 SHALL let clear_in take priority over flush_in.
REQ-023 SHALL ignore flush_in outside RUN.
REQ-024 SHALL drive state_out from the FSM state register.

Reset
REQ-025 SHALL on rst asynchronously set state IDLE, FIFO empty, rec_valid=0, rec_data=0, all counters=0, signature=0, overflow=0, state_out=0.
REQ-026 SHALL wait for pieo_reset_done_in=1 after rst deasserts before recording or counting.
REQ-027 SHALL, on rst mid-stream, discard pending FIFO records without delivering them.

Verification
REQ-028 SHALL cover: reset_done=1, then enq_valid=1 with enq_sublist=3 for 1 cycle, rec_ready=1 -> rec_valid=1 next cycle, flags=3'b001, enq_count=1, signature=F(record).
REQ-029 SHALL cover: enq, deq (element 0x55) and a move with moved_id MSB 0 in the same cycle -> a single record with flags=3'b111, enq_count=deq_count=1.
REQ-030 SHALL cover: rec_ready=0 with DEPTH+3 deq events -> DEPTH records held, drop_count=3, overflow=1; then rec_ready=1 -> exactly DEPTH records delivered in order.
REQ-031 SHALL cover: FIFO full plus pop and push in the same cycle -> push accepted, drop_count unchanged.
REQ-032 SHALL cover: flush_in with 4 records queued and events continuing -> state_out=2, no new pushes, counters advance, state_out=1 after the 4th pop.
REQ-033 SHALL cover: pieo_reset_done_in dropping in RUN -> state_out=0, later events ignored, queued records still drain; clear_in -> all statistics 0 next cycle.

Source files
------------

// File: rtl/pieo_result_monitor_if.sv
// pieo_result_monitor_if
//   Bundles the signals between a PIEO scheduler, the record consumer and
//   the status reader on one side and pieo_result_monitor on the other.
//   master : the environment (PIEO outputs, record sink, control, status reader)
//   slave  : the monitor
//   PIEO side   : pieo_reset_done_in, pieo_ready_in, enq_valid_in, enq_sublist_in,
//                 deq_valid_in, deq_element_in, moved_id_in, moved_sublist_in
//   control     : flush_in, clear_in
//   record      : rec_valid, rec_ready, rec_data
//   status      : enq_count, deq_count, drop_count, stall_count, signature,
//                 overflow, state_out
interface pieo_result_monitor_if #(
   parameter int ELEM_W = 32,
   parameter int SUB_W  = 5,
   parameter int ID_W   = 10
);
   localparam int REC_W = 3 + SUB_W + ELEM_W + ID_W + 1 + SUB_W;

   logic              pieo_reset_done_in;
   logic              pieo_ready_in;
   logic              enq_valid_in;
   logic [SUB_W-1:0]  enq_sublist_in;
   logic              deq_valid_in;
   logic [ELEM_W-1:0] deq_element_in;
   logic [ID_W:0]     moved_id_in;
   logic [SUB_W-1:0]  moved_sublist_in;
   logic              flush_in;
   logic              clear_in;
   logic              rec_valid;
   logic              rec_ready;
   logic [REC_W-1:0]  rec_data;
   logic [31:0]       enq_count;
   logic [31:0]       deq_count;
   logic [31:0]       drop_count;
   logic [31:0]       stall_count;
   logic [31:0]       signature;
   logic              overflow;
   logic [1:0]        state_out;

   modport master (
      output pieo_reset_done_in, pieo_ready_in, enq_valid_in, enq_sublist_in,
             deq_valid_in, deq_element_in, moved_id_in, moved_sublist_in,
             flush_in, clear_in, rec_ready,
      input  rec_valid, rec_data, enq_count, deq_count, drop_count,
             stall_count, signature, overflow, state_out
   );

   modport slave (
      input  pieo_reset_done_in, pieo_ready_in, enq_valid_in, enq_sublist_in,
             deq_valid_in, deq_element_in, moved_id_in, moved_sublist_in,
             flush_in, clear_in, rec_ready,
      output rec_valid, rec_data, enq_count, deq_count, drop_count,
             stall_count, signature, overflow, state_out
   );
endinterface

// File: rtl/pieo_result_monitor.sv
// pieo_result_monitor
//   Observes PIEO enqueue/dequeue/move activity, packs one record per event
//   cycle into a small FIFO exposed as a valid/ready stream, and keeps
//   saturating activity counters plus a rotating XOR signature.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pieo_result_monitor_if.slave (PIEO inputs, control, record
//              stream, status outputs)
//
//   state | meaning
//   IDLE  | PIEO not out of reset; events ignored, FIFO may still drain
//   RUN   | recording: events pushed, counted and signed
//   FLUSH | draining: events counted and signed but not pushed
module pieo_result_monitor #(
   parameter int ELEM_W = 32,
   parameter int SUB_W  = 5,
   parameter int ID_W   = 10,
   parameter int DEPTH  = 8
) (
   input logic                 clk,
   input logic                 rst,
   pieo_result_monitor_if.slave bus
);
   localparam int REC_W  = 3 + SUB_W + ELEM_W + ID_W + 1 + SUB_W;
   localparam int AW     = $clog2(DEPTH);
   localparam int NCHUNK = (REC_W + 31) / 32;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t            state_q;
   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic [31:0]       enq_cnt_q, deq_cnt_q, drop_cnt_q, stall_cnt_q, sig_q;
   logic              ovf_q;

   logic              move_w, active_w, event_w, full_w, empty_w;
   logic              pop_w, push_w, drop_w;
   logic [REC_W-1:0]  rec_w;
   logic [NCHUNK*32-1:0] rec_ext_w;
   logic [31:0]       fold_w;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // MSB of moved_id_in set means "no move this cycle".
   assign move_w   = ~bus.moved_id_in[ID_W];
   assign active_w = (state_q == RUN) || (state_q == FLUSH);
   assign event_w  = active_w && (bus.enq_valid_in || bus.deq_valid_in || move_w);
   assign rec_w    = {move_w, bus.deq_valid_in, bus.enq_valid_in, bus.enq_sublist_in,
                      bus.deq_element_in, bus.moved_id_in, bus.moved_sublist_in};
   assign full_w   = (count_q == (AW+1)'(DEPTH));
   assign empty_w  = (count_q == '0);
   assign pop_w    = !empty_w && bus.rec_ready;
   // A full FIFO that is popped this cycle still has room for the push.
   assign push_w   = event_w && (state_q == RUN) && (!full_w || pop_w);
   assign drop_w   = event_w && (state_q == RUN) && full_w && !pop_w;

   always_comb begin
      rec_ext_w = '0;
      rec_ext_w[REC_W-1:0] = rec_w;
      fold_w = '0;
      for (int i = 0; i < NCHUNK; i++) fold_w ^= rec_ext_w[i*32 +: 32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         enq_cnt_q   <= '0;
         deq_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         stall_cnt_q <= '0;
         sig_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         if (!bus.pieo_reset_done_in) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE:    state_q <= RUN;
               RUN:     if (bus.flush_in && !bus.clear_in) state_q <= FLUSH;
               FLUSH:   if (empty_w) state_q <= RUN;
               default: state_q <= IDLE;
            endcase
         end

         if (bus.clear_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            enq_cnt_q   <= '0;
            deq_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            stall_cnt_q <= '0;
            sig_q       <= '0;
            ovf_q       <= 1'b0;
         end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_w, pop_w})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
            if (active_w && bus.enq_valid_in)   enq_cnt_q   <= sat_inc(enq_cnt_q);
            if (active_w && bus.deq_valid_in)   deq_cnt_q   <= sat_inc(deq_cnt_q);
            if (active_w && !bus.pieo_ready_in) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (drop_w) begin
               drop_cnt_q <= sat_inc(drop_cnt_q);
               ovf_q      <= 1'b1;
            end
            if (event_w) sig_q <= {sig_q[30:0], sig_q[31]} ^ fold_w;
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q and the output
   // is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (push_w && !bus.clear_in) mem_q[wr_ptr_q] <= rec_w;
   end

   assign bus.rec_valid   = !empty_w;
   assign bus.rec_data    = empty_w ? '0 : mem_q[rd_ptr_q];
   assign bus.enq_count   = enq_cnt_q;
   assign bus.deq_count   = deq_cnt_q;
   assign bus.drop_count  = drop_cnt_q;
   assign bus.stall_count = stall_cnt_q;
   assign bus.signature   = sig_q;
   assign bus.overflow    = ovf_q;
   assign bus.state_out   = state_q;
endmodule

// File: tb/tb_pieo_result_monitor.sv
module tb_pieo_result_monitor;
   localparam int ELEM_W = 32;
   localparam int SUB_W  = 5;
   localparam int ID_W   = 10;
   localparam int DEPTH  = 8;
   localparam logic [10:0] NOMOVE = 11'h400;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pieo_result_monitor_if #(.ELEM_W(ELEM_W), .SUB_W(SUB_W), .ID_W(ID_W)) bus ();

   pieo_result_monitor #(.ELEM_W(ELEM_W), .SUB_W(SUB_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_enq = 0, exp_deq = 0, exp_sig = 0;

   function automatic logic [55:0] mk_rec(input logic e, input logic [4:0] sub, input logic d,
                                          input logic [31:0] el, input logic [10:0] mid,
                                          input logic [4:0] ms);
      return {~mid[10], d, e, sub, el, mid, ms};
   endfunction

   function automatic logic [31:0] sig_next(input logic [31:0] s, input logic [55:0] r);
      logic [31:0] f;
      f = r[31:0] ^ {8'h00, r[55:32]};
      return {s[30:0], s[31]} ^ f;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_ev(input logic e, input logic [4:0] sub, input logic d,
                         input logic [31:0] el, input logic [10:0] mid, input logic [4:0] ms);
      bus.enq_valid_in     = e;
      bus.enq_sublist_in   = sub;
      bus.deq_valid_in     = d;
      bus.deq_element_in   = el;
      bus.moved_id_in      = mid;
      bus.moved_sublist_in = ms;
   endtask

   task automatic idle_ev();
      set_ev(1'b0, 5'd0, 1'b0, 32'd0, NOMOVE, 5'd0);
   endtask

   // counted=1 when the DUT is in RUN/FLUSH at the coming edge.
   task automatic step(input bit counted);
      if (counted) begin
         if (bus.enq_valid_in || bus.deq_valid_in || !bus.moved_id_in[10])
            exp_sig = sig_next(exp_sig, mk_rec(bus.enq_valid_in, bus.enq_sublist_in,
                         bus.deq_valid_in, bus.deq_element_in, bus.moved_id_in,
                         bus.moved_sublist_in));
         if (bus.enq_valid_in) exp_enq++;
         if (bus.deq_valid_in) exp_deq++;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] elem_of(input logic [55:0] r);
      return r[16 +: 32];
   endfunction

   initial begin
      rst = 1'b1;
      bus.pieo_reset_done_in = 1'b0;
      bus.pieo_ready_in = 1'b1;
      bus.flush_in = 1'b0;
      bus.clear_in = 1'b0;
      bus.rec_ready = 1'b1;
      idle_ev();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 64'(bus.state_out), 64'd0);
      check("rst_valid", 64'(bus.rec_valid), 64'd0);
      check("rst_data", 64'(bus.rec_data), 64'd0);
      check("rst_enq", 64'(bus.enq_count), 64'd0);
      check("rst_sig", 64'(bus.signature), 64'd0);
      check("rst_ovf", 64'(bus.overflow), 64'd0);
      rst = 1'b0;

      // IDLE ignores events and flush
      set_ev(1'b1, 5'd2, 1'b1, 32'h11, 11'h001, 5'd1);
      bus.flush_in = 1'b1;
      step(0);
      step(0);
      bus.flush_in = 1'b0;
      check("idle_enq", 64'(bus.enq_count), 64'd0);
      check("idle_valid", 64'(bus.rec_valid), 64'd0);
      check("idle_state", 64'(bus.state_out), 64'd0);
      idle_ev();

      // single enqueue record
      bus.pieo_reset_done_in = 1'b1;
      step(0);
      check("run_state", 64'(bus.state_out), 64'd1);
      set_ev(1'b1, 5'd3, 1'b0, 32'd0, NOMOVE, 5'd0);
      step(1);
      idle_ev();
      check("enq_valid", 64'(bus.rec_valid), 64'd1);
      check("enq_flags", 64'(bus.rec_data[55:53]), 64'b001);
      check("enq_rec", 64'(bus.rec_data), 64'(mk_rec(1'b1, 5'd3, 1'b0, 32'd0, NOMOVE, 5'd0)));
      check("enq_cnt", 64'(bus.enq_count), 64'd1);
      check("enq_sig", 64'(bus.signature), 64'(exp_sig));
      step(1);
      check("enq_popped", 64'(bus.rec_valid), 64'd0);

      // clear
      bus.clear_in = 1'b1;
      set_ev(1'b1, 5'd4, 1'b0, 32'd0, NOMOVE, 5'd0);
      step(0);
      bus.clear_in = 1'b0;
      idle_ev();
      exp_enq = 0; exp_deq = 0; exp_sig = 0;
      check("clr_enq", 64'(bus.enq_count), 64'd0);
      check("clr_sig", 64'(bus.signature), 64'd0);
      check("clr_valid", 64'(bus.rec_valid), 64'd0);
      check("clr_state", 64'(bus.state_out), 64'd1);

      // simultaneous enq/deq/move -> one record
      set_ev(1'b1, 5'd1, 1'b1, 32'h55, 11'h005, 5'd2);
      step(1);
      idle_ev();
      check("tri_flags", 64'(bus.rec_data[55:53]), 64'b111);
      check("tri_rec", 64'(bus.rec_data), 64'(mk_rec(1'b1, 5'd1, 1'b1, 32'h55, 11'h005, 5'd2)));
      check("tri_enq", 64'(bus.enq_count), 64'd1);
      check("tri_deq", 64'(bus.deq_count), 64'd1);
      check("tri_sig", 64'(bus.signature), 64'(exp_sig));
      step(1);
      check("tri_popped", 64'(bus.rec_valid), 64'd0);

      // overflow: DEPTH+3 events with no consumer
      bus.rec_ready = 1'b0;
      for (int i = 1; i <= DEPTH + 3; i++) begin
         set_ev(1'b0, 5'd0, 1'b1, 32'(i), NOMOVE, 5'd0);
         step(1);
      end
      idle_ev();
      check("ovf_drop", 64'(bus.drop_count), 64'd3);
      check("ovf_flag", 64'(bus.overflow), 64'd1);
      check("ovf_head", 64'(elem_of(bus.rec_data)), 64'd1);
      check("ovf_deq", 64'(bus.deq_count), 64'(exp_deq));
      check("ovf_sig", 64'(bus.signature), 64'(exp_sig));
      step(1);
      check("hold_head", 64'(elem_of(bus.rec_data)), 64'd1);

      // full + pop + push in one cycle
      bus.rec_ready = 1'b1;
      set_ev(1'b0, 5'd0, 1'b1, 32'd100, NOMOVE, 5'd0);
      step(1);
      idle_ev();
      check("fpp_drop", 64'(bus.drop_count), 64'd3);
      for (int k = 2; k <= DEPTH; k++) begin
         check("drain_order", 64'(elem_of(bus.rec_data)), 64'(k));
         step(1);
      end
      check("drain_last", 64'(elem_of(bus.rec_data)), 64'd100);
      step(1);
      check("drain_empty", 64'(bus.rec_valid), 64'd0);

      // flush with 4 queued and ongoing events
      bus.rec_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_ev(1'b0, 5'd0, 1'b1, 32'hA0 + 32'(i), NOMOVE, 5'd0);
         step(1);
      end
      idle_ev();
      bus.flush_in = 1'b1;
      step(1);
      bus.flush_in = 1'b0;
      check("fl_state", 64'(bus.state_out), 64'd2);
      set_ev(1'b1, 5'd7, 1'b1, 32'hB0, NOMOVE, 5'd0);
      step(1);
      step(1);
      check("fl_head", 64'(elem_of(bus.rec_data)), 64'hA0);
      check("fl_deq", 64'(bus.deq_count), 64'(exp_deq));
      check("fl_enq", 64'(bus.enq_count), 64'(exp_enq));
      bus.rec_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("fl_order", 64'(elem_of(bus.rec_data)), 64'hA0 + 64'(k));
         step(1);
      end
      check("fl_empty", 64'(bus.rec_valid), 64'd0);
      check("fl_still", 64'(bus.state_out), 64'd2);
      step(1);
      idle_ev();
      check("fl_back", 64'(bus.state_out), 64'd1);
      check("fl_nopush", 64'(bus.rec_valid), 64'd0);
      check("fl_sig", 64'(bus.signature), 64'(exp_sig));

      // stalls
      bus.pieo_ready_in = 1'b0;
      repeat (3) step(1);
      bus.pieo_ready_in = 1'b1;
      check("stall_cnt", 64'(bus.stall_count), 64'd3);

      // reset_done drops with records queued
      bus.rec_ready = 1'b0;
      set_ev(1'b0, 5'd0, 1'b1, 32'hE0, NOMOVE, 5'd0);
      step(1);
      set_ev(1'b0, 5'd0, 1'b1, 32'hE1, NOMOVE, 5'd0);
      step(1);
      idle_ev();
      bus.pieo_reset_done_in = 1'b0;
      step(1);
      check("rd_state", 64'(bus.state_out), 64'd0);
      set_ev(1'b1, 5'd1, 1'b1, 32'hF0, NOMOVE, 5'd0);
      step(0);
      step(0);
      idle_ev();
      check("rd_enq", 64'(bus.enq_count), 64'(exp_enq));
      check("rd_deq", 64'(bus.deq_count), 64'(exp_deq));
      bus.rec_ready = 1'b1;
      check("rd_drain0", 64'(elem_of(bus.rec_data)), 64'hE0);
      step(0);
      check("rd_drain1", 64'(elem_of(bus.rec_data)), 64'hE1);
      step(0);
      check("rd_empty", 64'(bus.rec_valid), 64'd0);
      bus.clear_in = 1'b1;
      step(0);
      bus.clear_in = 1'b0;
      check("c2_enq", 64'(bus.enq_count), 64'd0);
      check("c2_deq", 64'(bus.deq_count), 64'd0);
      check("c2_drop", 64'(bus.drop_count), 64'd0);
      check("c2_stall", 64'(bus.stall_count), 64'd0);
      check("c2_sig", 64'(bus.signature), 64'd0);
      check("c2_ovf", 64'(bus.overflow), 64'd0);
      check("c2_state", 64'(bus.state_out), 64'd0);

      // reset mid-stream discards queued records
      bus.pieo_reset_done_in = 1'b1;
      step(0);
      bus.rec_ready = 1'b0;
      set_ev(1'b1, 5'd2, 1'b0, 32'd0, NOMOVE, 5'd0);
      step(1);
      idle_ev();
      check("mr_valid", 64'(bus.rec_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("mr_gone", 64'(bus.rec_valid), 64'd0);
      check("mr_data", 64'(bus.rec_data), 64'd0);
      check("mr_state", 64'(bus.state_out), 64'd0);
      check("mr_enq", 64'(bus.enq_count), 64'd0);
      rst = 1'b0;
      bus.rec_ready = 1'b1;
      step(0);
      check("mr_after", 64'(bus.rec_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
